// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM state encoding, queue entry layout and the PC alignment helper.
package fetch_unit_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ADDR_W  = 64;
   localparam int unsigned PC_STEP = 4;
   localparam int unsigned CNT_W   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fetch_entry_t;

   // Clear the byte offset so redirects always land on a word boundary.
   function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
      return addr & ~ADDR_W'(PC_STEP - 1);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Cache, decoder and redirect signals of the fetch unit grouped in one bundle.
// master is the fetch unit side, slave is the cache/decoder/execute side.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic               imemReq;
   logic [ADDR_W-1:0]  imemAddr;
   logic               imemValid;
   logic [INSTR_W-1:0] imemData;
   logic               instrValid;
   logic               instrReady;
   logic [INSTR_W-1:0] instruction;
   logic [ADDR_W-1:0]  instrPC;
   logic               branchTaken;
   logic [ADDR_W-1:0]  branchTarget;

   modport master (
      output imemReq, imemAddr, instrValid, instruction, instrPC,
      input  imemValid, imemData, instrReady, branchTaken, branchTarget
   );

   modport slave (
      input  imemReq, imemAddr, instrValid, instruction, instrPC,
      output imemValid, imemData, instrReady, branchTaken, branchTarget
   );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry shift FIFO for fetched instructions; slot0 is always the head.
// Flush wins over push and pop; pop happens before push in the same cycle.
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic             clock,
   input  logic             resetN,
   input  logic             push,
   input  fetch_entry_t     push_entry,
   input  logic             pop,
   input  logic             flush,
   output fetch_entry_t     head,
   output logic             valid,
   output logic [CNT_W-1:0] count
);

   fetch_entry_t     slot0_q, slot0_d;
   fetch_entry_t     slot1_q, slot1_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, valid_d;
   logic             do_pop;
   logic             do_push;

   // Next-state: shift on pop, then append at the first free slot.
   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      count_d = count_q;
      do_pop  = pop && (count_q != '0);
      do_push = 1'b0;
      if (flush) begin
         count_d = '0;
      end else begin
         if (do_pop) begin
            slot0_d = slot1_q;
            count_d = count_q - CNT_W'(1);
         end
         do_push = push && (count_d < CNT_W'(DEPTH));
         if (do_push) begin
            if (count_d == '0) begin
               slot0_d = push_entry;
            end else begin
               slot1_d = push_entry;
            end
            count_d = count_d + CNT_W'(1);
         end
      end
      valid_d = (count_d != '0);
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   assign head  = slot0_q;
   assign valid = valid_q;
   assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding cache request, PC sequencing and
// branch redirect, feeding a two-entry instruction queue toward the decoder.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
   parameter int unsigned       QDEPTH   = 2
) (
   input logic           clock,
   input logic           resetN,
   fetch_unit_if.master  bus
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              req_q, req_d;

   logic              q_push;
   logic              q_pop;
   logic              q_flush;
   fetch_entry_t      q_entry;
   fetch_entry_t      q_head;
   logic              q_valid;
   logic [CNT_W-1:0]  q_count;

   // Next-state, PC update and queue control.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      addr_d        = addr_q;
      q_push        = 1'b0;
      q_flush       = bus.branchTaken;
      q_pop         = bus.instrReady && q_valid && !bus.branchTaken;
      q_entry.instr = bus.imemData;
      q_entry.pc    = addr_q;

      if (bus.branchTaken) begin
         pc_d = align_word(bus.branchTarget);
      end

      unique case (state_q)
         IDLE: begin
            // Issue only when the response is guaranteed a free slot.
            if (!bus.branchTaken && (q_count < CNT_W'(QDEPTH))) begin
               state_d = WAIT;
               addr_d  = pc_q;
               pc_d    = pc_q + ADDR_W'(PC_STEP);
            end
         end
         WAIT: begin
            if (bus.branchTaken) begin
               state_d = bus.imemValid ? IDLE : DRAIN;
            end else if (bus.imemValid) begin
               q_push  = 1'b1;
               state_d = IDLE;
            end
         end
         DRAIN: begin
            // The stale response is swallowed; redirects only move the PC.
            if (bus.imemValid) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      req_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= '0;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
      end
   end

   fetch_queue #(
      .DEPTH (QDEPTH)
   ) u_queue (
      .clock      (clock),
      .resetN     (resetN),
      .push       (q_push),
      .push_entry (q_entry),
      .pop        (q_pop),
      .flush      (q_flush),
      .head       (q_head),
      .valid      (q_valid),
      .count      (q_count)
   );

   assign bus.imemReq     = req_q;
   assign bus.imemAddr    = addr_q;
   assign bus.instrValid  = q_valid;
   assign bus.instruction = q_head.instr;
   assign bus.instrPC     = q_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against an instruction-stream model (sequential PCs, redirects).
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        clock = 1'b0;
   logic        resetN;
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   fetch_unit_if bus();
   fetch_unit_if bus_w();

   logic        auto_cache;
   logic        rand_lat;
   logic        c_valid;
   logic [31:0] c_data;
   int unsigned c_cnt;
   int unsigned c_lat;
   logic        m_valid;
   logic [31:0] m_data;

   logic [63:0] cap_pc[$];
   logic [31:0] cap_word[$];
   logic [63:0] cap_addr[$];

   assign bus.imemValid = auto_cache ? c_valid : m_valid;
   assign bus.imemData  = auto_cache ? c_data  : m_data;

   fetch_unit #(.RESET_PC(64'h0), .QDEPTH(2)) u_dut (
      .clock  (clock),
      .resetN (resetN),
      .bus    (bus)
   );

   fetch_unit #(.RESET_PC(WRAP_PC), .QDEPTH(2)) u_wrap (
      .clock  (clock),
      .resetN (resetN),
      .bus    (bus_w)
   );

   initial forever #5 clock = ~clock;

   function automatic logic [31:0] word_of(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   // Cache model: answers after c_lat cycles with a word derived from the address.
   initial begin
      c_valid = 1'b0;
      c_data  = '0;
      c_cnt   = 0;
      c_lat   = 1;
      forever begin
         @(posedge clock);
         #1;
         if (!resetN || !bus.imemReq) begin
            c_cnt   = 0;
            c_valid = 1'b0;
         end else begin
            if (c_cnt == 0) c_lat = rand_lat ? $urandom_range(1, 4) : 1;
            c_cnt   = c_cnt + 1;
            c_valid = (c_cnt >= c_lat);
            c_data  = word_of(bus.imemAddr);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish by time limit, want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      tick();
      resetN           = 1'b0;
      bus.instrReady   = 1'b0;
      bus.branchTaken  = 1'b0;
      bus.branchTarget = '0;
      m_valid          = 1'b0;
      m_data           = '0;
      tick();
      tick();
      resetN = 1'b1;
   endtask

   task automatic capture(input int n, input int budget);
      logic prev;
      prev = 1'b0;
      cap_pc.delete();
      cap_word.delete();
      cap_addr.delete();
      for (int i = 0; i < budget && cap_pc.size() < n; i++) begin
         @(negedge clock);
         if (bus.imemReq && !prev) cap_addr.push_back(bus.imemAddr);
         prev = bus.imemReq;
         if (bus.instrValid && bus.instrReady) begin
            cap_pc.push_back(bus.instrPC);
            cap_word.push_back(bus.instruction);
         end
      end
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      auto_cache = 1'b1;
      rand_lat = 1'b0;
      bus.instrReady = 1'b0;
      bus.branchTaken = 1'b0;
      bus.branchTarget = '0;
      m_valid = 1'b0;
      m_data = '0;
      tick();
      tick();
      @(negedge clock);
      n_checks++; if (bus.imemReq !== 1'b0) $display("FAIL reset_req: got %0b want 0", bus.imemReq); else n_pass++;
      n_checks++; if (bus.instrValid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.instrValid); else n_pass++;
      n_checks++; if (bus.instruction !== 32'h0) $display("FAIL reset_instr: got %h want 0", bus.instruction); else n_pass++;
      n_checks++; if (bus.instrPC !== 64'h0) $display("FAIL reset_pc: got %h want 0", bus.instrPC); else n_pass++;
      tick();
      resetN = 1'b1;
      @(negedge clock);
      n_checks++; if (bus.imemReq !== 1'b0) $display("FAIL release_req_early: got %0b want 0", bus.imemReq); else n_pass++;
      @(negedge clock);
      n_checks++; if (bus.imemReq !== 1'b1) $display("FAIL first_req: got %0b want 1", bus.imemReq); else n_pass++;
      n_checks++; if (bus.imemAddr !== 64'h0) $display("FAIL first_addr: got %h want 0", bus.imemAddr); else n_pass++;
   endtask

   task automatic test_sequential();
      logic [63:0] got_a;
      logic [63:0] got_p;
      logic [31:0] got_w;
      auto_cache = 1'b1;
      rand_lat = 1'b0;
      do_reset();
      bus.instrReady = 1'b1;
      capture(3, 40);
      n_checks++; if (cap_pc.size() != 3) $display("FAIL seq_count: got %0d want 3", cap_pc.size()); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         got_a = '1; got_p = '1; got_w = '1;
         if (k < cap_addr.size()) got_a = cap_addr[k];
         if (k < cap_pc.size()) begin got_p = cap_pc[k]; got_w = cap_word[k]; end
         n_checks++; if (got_a !== 64'(4 * k)) $display("FAIL seq_addr%0d: got %h want %h", k, got_a, 64'(4 * k)); else n_pass++;
         n_checks++; if (got_p !== 64'(4 * k)) $display("FAIL seq_pc%0d: got %h want %h", k, got_p, 64'(4 * k)); else n_pass++;
         n_checks++; if (got_w !== word_of(64'(4 * k))) $display("FAIL seq_word%0d: got %h want %h", k, got_w, word_of(64'(4 * k))); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int          late_req;
      logic [63:0] got_p;
      logic [31:0] got_w;
      auto_cache = 1'b1;
      rand_lat = 1'b0;
      do_reset();
      late_req = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (i >= 6 && bus.imemReq) late_req++;
      end
      n_checks++; if (late_req != 0) $display("FAIL bp_req_full: got %0d cycles with req want 0", late_req); else n_pass++;
      n_checks++; if (bus.instrValid !== 1'b1) $display("FAIL bp_valid: got %0b want 1", bus.instrValid); else n_pass++;
      n_checks++; if (bus.instrPC !== 64'h0) $display("FAIL bp_head_pc: got %h want 0", bus.instrPC); else n_pass++;
      tick();
      bus.instrReady = 1'b1;
      capture(3, 40);
      for (int k = 0; k < 3; k++) begin
         got_p = '1; got_w = '1;
         if (k < cap_pc.size()) begin got_p = cap_pc[k]; got_w = cap_word[k]; end
         n_checks++; if (got_p !== 64'(4 * k)) $display("FAIL bp_pc%0d: got %h want %h", k, got_p, 64'(4 * k)); else n_pass++;
         n_checks++; if (got_w !== word_of(64'(4 * k))) $display("FAIL bp_word%0d: got %h want %h", k, got_w, word_of(64'(4 * k))); else n_pass++;
      end
   endtask

   task automatic test_branch_wait();
      auto_cache = 1'b0;
      do_reset();
      tick();
      m_valid = 1'b1; m_data = word_of(64'h0);
      tick();
      m_valid = 1'b0;
      tick();
      bus.branchTaken = 1'b1; bus.branchTarget = 64'h100;
      @(negedge clock);
      n_checks++; if (bus.imemAddr !== 64'h4 || bus.imemReq !== 1'b1) $display("FAIL bw_wait_addr: got %h/%0b want 4/1", bus.imemAddr, bus.imemReq); else n_pass++;
      n_checks++; if (bus.instrValid !== 1'b1 || bus.instrPC !== 64'h0) $display("FAIL bw_held: got %0b/%h want 1/0", bus.instrValid, bus.instrPC); else n_pass++;
      tick();
      bus.branchTaken = 1'b0;
      @(negedge clock);
      n_checks++; if (bus.instrValid !== 1'b0) $display("FAIL bw_flush: got %0b want 0", bus.instrValid); else n_pass++;
      n_checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 64'h4) $display("FAIL bw_drain: got %0b/%h want 1/4", bus.imemReq, bus.imemAddr); else n_pass++;
      tick();
      m_valid = 1'b1; m_data = word_of(64'h4);
      tick();
      m_valid = 1'b0;
      @(negedge clock);
      n_checks++; if (bus.instrValid !== 1'b0 || bus.imemReq !== 1'b0) $display("FAIL bw_stale_drop: got %0b/%0b want 0/0", bus.instrValid, bus.imemReq); else n_pass++;
      tick();
      m_valid = 1'b1; m_data = word_of(64'h100);
      @(negedge clock);
      n_checks++; if (bus.imemAddr !== 64'h100) $display("FAIL bw_redirect_addr: got %h want 100", bus.imemAddr); else n_pass++;
      tick();
      m_valid = 1'b0;
      @(negedge clock);
      n_checks++; if (bus.instrValid !== 1'b1 || bus.instrPC !== 64'h100) $display("FAIL bw_new_pc: got %0b/%h want 1/100", bus.instrValid, bus.instrPC); else n_pass++;
      n_checks++; if (bus.instruction !== word_of(64'h100)) $display("FAIL bw_new_word: got %h want %h", bus.instruction, word_of(64'h100)); else n_pass++;
   endtask

   task automatic test_branch_same_cycle();
      auto_cache = 1'b0;
      do_reset();
      tick();
      m_valid = 1'b1; m_data = word_of(64'h0);
      bus.branchTaken = 1'b1; bus.branchTarget = 64'h203;
      tick();
      m_valid = 1'b0; bus.branchTaken = 1'b0;
      @(negedge clock);
      n_checks++; if (bus.instrValid !== 1'b0 || bus.imemReq !== 1'b0) $display("FAIL bs_drop: got %0b/%0b want 0/0", bus.instrValid, bus.imemReq); else n_pass++;
      tick();
      m_valid = 1'b1; m_data = word_of(64'h200);
      @(negedge clock);
      n_checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 64'h200) $display("FAIL bs_addr: got %0b/%h want 1/200", bus.imemReq, bus.imemAddr); else n_pass++;
      tick();
      m_valid = 1'b0;
      @(negedge clock);
      n_checks++; if (bus.instrValid !== 1'b1 || bus.instrPC !== 64'h200) $display("FAIL bs_pc: got %0b/%h want 1/200", bus.instrValid, bus.instrPC); else n_pass++;
   endtask

   task automatic test_reset_mid_request();
      auto_cache = 1'b0;
      do_reset();
      tick();
      @(negedge clock);
      n_checks++; if (bus.imemReq !== 1'b1) $display("FAIL rm_wait: got %0b want 1", bus.imemReq); else n_pass++;
      resetN = 1'b0;
      #1;
      n_checks++; if (bus.imemReq !== 1'b0) $display("FAIL rm_async_req: got %0b want 0", bus.imemReq); else n_pass++;
      tick();
      resetN = 1'b1;
      m_valid = 1'b1; m_data = 32'hBAD0_BAD0;
      @(negedge clock);
      n_checks++; if (bus.imemReq !== 1'b0) $display("FAIL rm_idle: got %0b want 0", bus.imemReq); else n_pass++;
      tick();
      m_valid = 1'b0;
      @(negedge clock);
      n_checks++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 64'h0) $display("FAIL rm_first_addr: got %0b/%h want 1/0", bus.imemReq, bus.imemAddr); else n_pass++;
      n_checks++; if (bus.instrValid !== 1'b0) $display("FAIL rm_stale_valid: got %0b want 0", bus.instrValid); else n_pass++;
      tick();
      @(negedge clock);
      n_checks++; if (bus.instrValid !== 1'b0) $display("FAIL rm_no_resp: got %0b want 0", bus.instrValid); else n_pass++;
      m_valid = 1'b1; m_data = word_of(64'h0);
      tick();
      m_valid = 1'b0;
      @(negedge clock);
      n_checks++; if (bus.instrValid !== 1'b1 || bus.instruction !== word_of(64'h0)) $display("FAIL rm_resp: got %0b/%h want 1/%h", bus.instrValid, bus.instruction, word_of(64'h0)); else n_pass++;
   endtask

   task automatic test_wrap();
      bus_w.imemValid = 1'b0;
      bus_w.imemData  = '0;
      do_reset();
      tick();
      bus_w.imemValid = 1'b1; bus_w.imemData = 32'h0000_0013;
      @(negedge clock);
      n_checks++; if (bus_w.imemReq !== 1'b1 || bus_w.imemAddr !== WRAP_PC) $display("FAIL wrap_first: got %0b/%h want 1/%h", bus_w.imemReq, bus_w.imemAddr, WRAP_PC); else n_pass++;
      tick();
      bus_w.imemValid = 1'b0;
      @(negedge clock);
      n_checks++; if (bus_w.instrValid !== 1'b1 || bus_w.instrPC !== WRAP_PC) $display("FAIL wrap_head: got %0b/%h want 1/%h", bus_w.instrValid, bus_w.instrPC, WRAP_PC); else n_pass++;
      tick();
      @(negedge clock);
      n_checks++; if (bus_w.imemReq !== 1'b1 || bus_w.imemAddr !== 64'h0) $display("FAIL wrap_second: got %0b/%h want 1/0", bus_w.imemReq, bus_w.imemAddr); else n_pass++;
   endtask

   // Delivered stream must be consecutive words, restarting at each aligned redirect target.
   task automatic test_random();
      logic [63:0] exp_pc;
      logic [63:0] prev_addr;
      logic        prev_req;
      logic        post_br;
      int          delivered;
      auto_cache = 1'b1;
      rand_lat = 1'b1;
      do_reset();
      exp_pc = 64'h0; prev_addr = '0; prev_req = 1'b0; post_br = 1'b0; delivered = 0;
      for (int i = 0; i < 800; i++) begin
         bus.instrReady   = ($urandom_range(0, 9) < 7);
         bus.branchTaken  = ($urandom_range(0, 39) == 0);
         bus.branchTarget = {$urandom, $urandom};
         @(negedge clock);
         if (post_br) begin
            n_checks++; if (bus.instrValid !== 1'b0) $display("FAIL rnd_post_redirect_valid: cycle %0d got %0b want 0", i, bus.instrValid); else n_pass++;
         end
         if (bus.imemReq && prev_req) begin
            n_checks++; if (bus.imemAddr !== prev_addr) $display("FAIL rnd_addr_stable: cycle %0d got %h want %h", i, bus.imemAddr, prev_addr); else n_pass++;
         end
         if (bus.branchTaken) begin
            exp_pc  = bus.branchTarget & ~64'h3;
            post_br = 1'b1;
         end else begin
            post_br = 1'b0;
            if (bus.instrValid && bus.instrReady) begin
               n_checks++; if (bus.instrPC !== exp_pc) $display("FAIL rnd_pc: cycle %0d got %h want %h", i, bus.instrPC, exp_pc); else n_pass++;
               n_checks++; if (bus.instruction !== word_of(exp_pc)) $display("FAIL rnd_word: cycle %0d got %h want %h", i, bus.instruction, word_of(exp_pc)); else n_pass++;
               exp_pc = exp_pc + 64'd4;
               delivered++;
            end
         end
         prev_req  = bus.imemReq;
         prev_addr = bus.imemAddr;
         tick();
      end
      bus.branchTaken = 1'b0;
      n_checks++; if (delivered < 80) $display("FAIL rnd_progress: got %0d delivered want >= 80", delivered); else n_pass++;
   endtask

   initial begin
      bus_w.imemValid    = 1'b0;
      bus_w.imemData     = '0;
      bus_w.instrReady   = 1'b0;
      bus_w.branchTaken  = 1'b0;
      bus_w.branchTarget = '0;
      test_reset();
      test_sequential();
      test_backpressure();
      test_branch_wait();
      test_branch_same_cycle();
      test_reset_mid_request();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
